conv_sched: RTL

Window/kernel scheduler for the clk2-domain 2x2 convolution datapath. After the 6x6 ifmap and six 2x2 kernels are loaded, it walks every output position for every kernel and drives the datapath select lanes. It gates the datapath result register and issues one FIFO write per result, stalling on `fifo_full`. It replaces ad-hoc counter logic inside the compute module with a single sequencer that has a clean start/busy/done contract.

---
 rtl/conv_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/conv_sched.sv
// conv_sched: window/kernel sequencer for the 2x2 convolution datapath.
// Walks every (x,y,k) output position and paces result writes into the FIFO.
module conv_sched #(
    parameter int IMG_W = 6,
    parameter int KER_W = 2,
    parameter int NUM_K = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       fifo_full,
    output logic [2:0] ifmap_x,
    output logic [2:0] ifmap_y,
    output logic [2:0] kernel_idx,
    output logic       mac_en,
    output logic       fifo_winc,
    output logic       busy,
    output logic       done,
    output logic [7:0] out_cnt
);

    localparam int         OUT_W = IMG_W - KER_W + 1;
    localparam logic [2:0] XY_MAX = 3'(OUT_W - 1);
    localparam logic [2:0] K_MAX  = 3'(NUM_K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;
    logic   v1;
    logic   x_end;
    logic   y_end;
    logic   last;

    assign x_end = (ifmap_x == XY_MAX);
    assign y_end = (ifmap_y == XY_MAX);
    assign last  = x_end && y_end && (kernel_idx == K_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus issue/write strobes; a full FIFO freezes everything.
    always_comb begin
        state_nx  = state;
        mac_en    = 1'b0;
        fifo_winc = v1 && !fifo_full;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (!fifo_full) begin
                    mac_en = 1'b1;
                    if (last) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!fifo_full) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Position counters: x fastest, then y, then kernel; cleared after the last issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifmap_x    <= '0;
            ifmap_y    <= '0;
            kernel_idx <= '0;
        end else if (mac_en) begin
            if (last) begin
                ifmap_x    <= '0;
                ifmap_y    <= '0;
                kernel_idx <= '0;
            end else if (!x_end) begin
                ifmap_x <= ifmap_x + 3'd1;
            end else begin
                ifmap_x <= '0;
                if (!y_end) begin
                    ifmap_y <= ifmap_y + 3'd1;
                end else begin
                    ifmap_y    <= '0;
                    kernel_idx <= kernel_idx + 3'd1;
                end
            end
        end
    end

    // Result-pending flag tracks the one-cycle datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (mac_en) begin
            v1 <= 1'b1;
        end else if (state == DRAIN && !fifo_full) begin
            v1 <= 1'b0;
        end
    end

    // Write counter, cleared when a pass is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (state == IDLE && start) begin
            out_cnt <= '0;
        end else if (fifo_winc) begin
            out_cnt <= out_cnt + 8'd1;
        end
    end

    // Completion pulse, one cycle after the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && !fifo_full;
        end
    end

endmodule
